// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RISC-V datapath: sequences fetch, decode,
// execute, memory and writeback steps and drives the datapath select/enable lines.
module multicycle_controller #(
   parameter logic HANDSHAKE = 1'b1,
   parameter logic TRAP_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op_code,
   input  logic [2:0] func3,
   input  logic       func7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      JALRLINK = 4'd12,
      LUI      = 4'd13,
      TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   state_t state_q, state_next;
   logic   illegal_q;
   logic   mem_rdy;
   logic   pc_write_c, mem_write_c, ir_write_c, reg_write_c;

   // With the handshake disabled every memory access completes in one cycle.
   assign mem_rdy = HANDSHAKE ? mem_ready : 1'b1;

   function automatic logic [3:0] func_alu(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
      logic [3:0] ctl;
      case (f3)
         3'b000:  ctl = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  ctl = ALU_SLL;
         3'b010:  ctl = ALU_SLT;
         3'b011:  ctl = ALU_SLTU;
         3'b100:  ctl = ALU_XOR;
         3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  ctl = ALU_OR;
         default: ctl = ALU_AND;
      endcase
      return ctl;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_next;
         if (state_next == TRAP) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state_q;
      pc_write_c  = 1'b0;
      adr_src     = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      case (state_q)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_rdy) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op_code)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECR;
               OP_ITYPE:          state_next = EXECI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               OP_JALR:           state_next = JALR;
               OP_LUI:            state_next = LUI;
               default:           state_next = TRAP_EN ? TRAP : FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (op_code == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (mem_rdy) state_next = MEMWB;
         end
         MEMWB: begin
            result_src  = 2'b01;
            reg_write_c = 1'b1;
            state_next  = FETCH;
         end
         MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            if (mem_rdy) state_next = FETCH;
         end
         EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = func_alu(func3, func7b5, 1'b1);
            state_next  = ALUWB;
         end
         EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = func_alu(func3, func7b5, 1'b0);
            state_next  = ALUWB;
         end
         ALUWB: begin
            reg_write_c = 1'b1;
            state_next  = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            state_next = FETCH;
            // blt/bltu take the branch when the compare result is nonzero.
            case (func3)
               3'b000, 3'b001: alu_control = ALU_SUB;
               3'b100, 3'b101: alu_control = ALU_SLT;
               3'b110, 3'b111: alu_control = ALU_SLTU;
               default:        alu_control = ALU_ADD;
            endcase
            case (func3)
               3'b000, 3'b101, 3'b111: pc_write_c = zero;
               3'b001, 3'b100, 3'b110: pc_write_c = ~zero;
               default:                pc_write_c = 1'b0;
            endcase
         end
         JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_write_c = 1'b1;
            state_next = ALUWB;
         end
         JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write_c = 1'b1;
            state_next = JALRLINK;
         end
         JALRLINK: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            state_next = ALUWB;
         end
         LUI: begin
            alu_src_a  = 2'b11;
            alu_src_b  = 2'b01;
            state_next = ALUWB;
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      case (op_code)
         OP_STORE:  imm_src = 3'b001;
         OP_BRANCH: imm_src = 3'b010;
         OP_JAL:    imm_src = 3'b011;
         OP_LUI:    imm_src = 3'b100;
         default:   imm_src = 3'b000;
      endcase
   end

   // Write enables are forced low for the whole time reset is held.
   assign pc_write  = pc_write_c  & rst_n;
   assign ir_write  = ir_write_c  & rst_n;
   assign mem_write = mem_write_c & rst_n;
   assign reg_write = reg_write_c & rst_n;
   assign illegal   = illegal_q;
   assign state     = state_q;

endmodule
